// File: rtl/le7s_scan_pkg.sv
// rtl/le7s_scan_pkg.sv - shared seven-segment constants and scan FSM states
package pkg7s;

  // Active-high lit patterns, bit0=a .. bit6=g
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    HELD
  } state_t;

endpackage

// File: rtl/le7s_scan_dec7s.sv
// rtl/le7s_scan_dec7s.sv - active-low segment pattern to hex nibble decoder
module dec7s
  import pkg7s::*;
(
  input  logic [6:0] seg_n_i,
  output logic [3:0] valor_o,
  output logic       conhecido_o,
  output logic       apagado_o
);

  logic [6:0] lit;

  always_comb begin
    lit         = ~seg_n_i;
    valor_o     = 4'h0;
    conhecido_o = 1'b1;
    apagado_o   = 1'b0;
    case (lit)
      SEG_0:     valor_o = 4'h0;
      SEG_1:     valor_o = 4'h1;
      SEG_2:     valor_o = 4'h2;
      SEG_3:     valor_o = 4'h3;
      SEG_4:     valor_o = 4'h4;
      SEG_5:     valor_o = 4'h5;
      SEG_6:     valor_o = 4'h6;
      SEG_7:     valor_o = 4'h7;
      SEG_8:     valor_o = 4'h8;
      SEG_9:     valor_o = 4'h9;
      SEG_A:     valor_o = 4'hA;
      SEG_B:     valor_o = 4'hB;
      SEG_C:     valor_o = 4'hC;
      SEG_D:     valor_o = 4'hD;
      SEG_E:     valor_o = 4'hE;
      SEG_F:     valor_o = 4'hF;
      SEG_BLANK: begin
        conhecido_o = 1'b0;
        apagado_o   = 1'b1;
      end
      default:   conhecido_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/le7s_scan.sv
// rtl/le7s_scan.sv - multiplexed seven-segment bus reader, one decoded nibble per digit
module le7s_scan
  import pkg7s::*;
#(
  parameter int DIGITS = 4,
  parameter int STABLE = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DIGITS-1:0]     anodos,
  input  logic [6:0]            segmentos,
  output logic [4*DIGITS-1:0]   numeros,
  output logic [DIGITS-1:0]     valido,
  output logic [DIGITS-1:0]     erro,
  output logic                  atualizado
);

  localparam int CW = $clog2(STABLE);

  logic [DIGITS-1:0]   anodos_r, anodos_p;
  logic [6:0]          segmentos_r, segmentos_p;
  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [4*DIGITS-1:0] numeros_q;
  logic [DIGITS-1:0]   valido_q, erro_q;
  logic                atualizado_q;

  logic                changed, one_hot;
  logic [DIGITS-1:0]   sel;
  logic [3:0]          valor;
  logic                conhecido, apagado;

  assign sel     = ~anodos_r;
  assign one_hot = $onehot(sel);
  assign changed = (anodos_r != anodos_p) || (segmentos_r != segmentos_p);

  dec7s u_dec (
    .seg_n_i     (segmentos_r),
    .valor_o     (valor),
    .conhecido_o (conhecido),
    .apagado_o   (apagado)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      anodos_r     <= '1;
      anodos_p     <= '1;
      segmentos_r  <= '1;
      segmentos_p  <= '1;
      state_q      <= IDLE;
      cnt_q        <= '0;
      numeros_q    <= '0;
      valido_q     <= '0;
      erro_q       <= '0;
      atualizado_q <= 1'b0;
    end else begin
      anodos_r     <= anodos;
      segmentos_r  <= segmentos;
      anodos_p     <= anodos_r;
      segmentos_p  <= segmentos_r;
      atualizado_q <= 1'b0;
      if (changed) begin
        cnt_q   <= '0;
        state_q <= one_hot ? TRACK : IDLE;
      end else begin
        case (state_q)
          TRACK: begin
            cnt_q <= cnt_q + 1'b1;
            // Reaching STABLE-1 on this edge is the commit; HELD keeps the count parked there.
            if (cnt_q == CW'(STABLE - 2)) begin
              state_q      <= HELD;
              atualizado_q <= 1'b1;
              for (int i = 0; i < DIGITS; i++) begin
                if (sel[i]) begin
                  valido_q[i] <= conhecido;
                  erro_q[i]   <= !conhecido && !apagado;
                  if (conhecido) numeros_q[4*i +: 4] <= valor;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign numeros    = numeros_q;
  assign valido     = valido_q;
  assign erro       = erro_q;
  assign atualizado = atualizado_q;

endmodule

// File: tb/tb_le7s_scan.sv
// tb/tb_le7s_scan.sv - bench for le7s_scan with a run-length reference model
module tb_le7s_scan;

  localparam int DIGITS = 4;
  localparam int STABLE = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  anodos;
  logic [6:0]  segmentos;
  logic [15:0] numeros;
  logic [3:0]  valido, erro;
  logic        atualizado;

  always #5 clk = ~clk;

  le7s_scan #(.DIGITS(DIGITS), .STABLE(STABLE)) dut (
    .clk        (clk),
    .reset      (reset),
    .anodos     (anodos),
    .segmentos  (segmentos),
    .numeros    (numeros),
    .valido     (valido),
    .erro       (erro),
    .atualizado (atualizado)
  );

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int nvec = 0;
  int nmis = 0;
  int npulse = 0;
  int mpulse = 0;
  bit checking = 1'b0;

  // Model: a commit lands on the edge where the last STABLE sampled words agree
  // and the word before them differed, with exactly one anode low.
  logic [10:0] hist [STABLE+1];
  logic [15:0] m_num;
  logic [3:0]  m_val, m_err;
  logic        m_pulse;
  logic [6:0]  m_lit;
  logic [3:0]  m_an;
  int          m_k;
  bit          m_run;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= STABLE; i++) hist[i] = 11'h7FF;
      m_num = '0; m_val = '0; m_err = '0; m_pulse = 1'b0;
    end else begin
      m_pulse = 1'b0;
      m_run = 1'b1;
      for (int i = 1; i < STABLE; i++) if (hist[i] != hist[0]) m_run = 1'b0;
      m_an = hist[0][10:7];
      if (m_run && hist[STABLE] != hist[0] && $countones(~m_an) == 1) begin
        m_lit = ~hist[0][6:0];
        m_k = -1;
        for (int v = 0; v < 16; v++) if (seg_tab[v] == m_lit) m_k = v;
        for (int d = 0; d < DIGITS; d++) begin
          if (!m_an[d]) begin
            if (m_k >= 0) begin
              m_num[4*d +: 4] = 4'(m_k); m_val[d] = 1'b1; m_err[d] = 1'b0;
            end else begin
              m_val[d] = 1'b0; m_err[d] = (m_lit != 7'h00);
            end
          end
        end
        m_pulse = 1'b1;
        mpulse++;
      end
      for (int i = STABLE; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {anodos, segmentos};
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      nvec++;
      if ({numeros, valido, erro, atualizado} !== {m_num, m_val, m_err, m_pulse}) begin
        nmis++;
        $display("FAIL cycle @%0t: dut num=%h val=%b err=%b upd=%b, model num=%h val=%b err=%b upd=%b",
                 $time, numeros, valido, erro, atualizado, m_num, m_val, m_err, m_pulse);
      end
      if (atualizado === 1'b1) npulse++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs are sampled by the next n rising edges; returns after the nth falling edge.
  task automatic apply(input logic [3:0] an, input logic [6:0] seg, input int n);
    anodos = an;
    segmentos = seg;
    repeat (n) @(negedge clk);
    #1;
  endtask

  int p0;
  logic [15:0] exp_num;

  initial begin
    reset = 1'b1;
    anodos = 4'($urandom);
    segmentos = 7'($urandom);
    @(posedge clk);
    #1 checking = 1'b1;
    apply(4'($urandom), 7'($urandom), 1);
    reset = 1'b0;
    chk("reset_numeros", 32'(numeros), 32'h0);
    chk("reset_flags", {24'h0, valido, erro}, 32'h0);
    chk("reset_pulse", 32'(npulse), 32'd0);
    apply(4'hF, 7'h7F, 3);

    // basic decode: digit 2 shows 5, commit on the STABLE-th edge
    p0 = npulse;
    apply(4'b1011, ~7'h6D, 4);
    chk("basic_no_early_pulse", 32'(npulse), 32'(p0));
    apply(4'b1011, ~7'h6D, 1);
    chk("basic_pulse_now", 32'(atualizado), 32'd1);
    apply(4'b1011, ~7'h6D, 1);
    chk("basic_one_pulse", 32'(npulse), 32'(p0 + 1));
    chk("basic_digit2", 32'(numeros[11:8]), 32'd5);
    chk("basic_valido", 32'(valido), 32'b0100);
    chk("model_digit2", 32'(m_num[11:8]), 32'd5);

    // glitch shorter than STABLE, then restore: exactly one re-commit
    p0 = npulse;
    apply(4'b1011, ~7'h7F, 3);
    apply(4'b1011, ~7'h6D, 6);
    chk("glitch_one_recommit", 32'(npulse), 32'(p0 + 1));
    chk("glitch_digit2", 32'(numeros[11:8]), 32'd5);

    // unknown pattern then blank on digit 0
    apply(4'b1110, ~7'h01, 6);
    chk("err_erro", 32'(erro), 32'b0001);
    chk("err_valido", 32'(valido), 32'b0100);
    apply(4'b1110, ~7'h00, 6);
    chk("blank_erro", 32'(erro), 32'b0000);
    chk("blank_valido", 32'(valido), 32'b0100);

    // invalid anode patterns never commit
    p0 = npulse;
    apply(4'b0011, ~7'h06, 20);
    apply(4'b1111, ~7'h06, 20);
    chk("invalid_no_pulse", 32'(npulse), 32'(p0));
    chk("invalid_digit2", 32'(numeros[11:8]), 32'd5);
    chk("invalid_model_pulses", 32'(mpulse), 32'(npulse));

    // round trip through an encoder + scanner, STABLE cycles per slot
    p0 = npulse;
    for (int pass = 0; pass < 16; pass++) begin
      for (int d = 0; d < DIGITS; d++) begin
        logic [3:0] an;
        an = ~(4'b0001 << d);
        apply(an, ~seg_tab[(pass + d) % 16], STABLE);
      end
      apply(4'hF, 7'h7F, 1);
      exp_num = '0;
      for (int d = 0; d < DIGITS; d++) exp_num[4*d +: 4] = 4'((pass + d) % 16);
      chk("roundtrip_numeros", 32'(numeros), 32'(exp_num));
      chk("roundtrip_valido", 32'(valido), 32'hF);
    end
    chk("roundtrip_pulses", 32'(npulse), 32'(p0 + 64));

    // reset when the count has reached 2: no commit, outputs cleared
    p0 = npulse;
    apply(4'b1101, ~7'h6F, 4);
    reset = 1'b1;
    apply(4'hF, 7'h7F, 1);
    reset = 1'b0;
    chk("rst_mid_pulse", 32'(atualizado), 32'd0);
    chk("rst_mid_numeros", 32'(numeros), 32'h0);
    chk("rst_mid_flags", {24'h0, valido, erro}, 32'h0);
    apply(4'hF, 7'h7F, 6);
    chk("rst_mid_no_commit", 32'(npulse), 32'(p0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/le7s_scan.md
# le7s_scan

Scanning seven-segment reader: the receive side of the multiplexed display bus that the hex-to-segment encoder and digit scanner drive. It samples the active-low anode and segment lines, waits for each digit slot to settle, decodes the segment pattern back to a 4-bit value, and holds one decoded nibble per digit. It sits beside the score/status display so on-chip self-test and the verification bench can read what the board actually displays.

## Interface
- `DIGITS`, default 4: number of multiplexed digits (1–8).
- `STABLE`, default 4: consecutive cycles a slot must stay unchanged before commit (minimum 2).
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `anodos`  in  DIGITS  digit selects, active-low; a valid slot has exactly one bit low.
- `segmentos`  in  7  segment lines, active-low; bit0=a … bit6=g.
- `numeros`  out  4*DIGITS  decoded nibble per digit; digit d at [4d+3:4d].
- `valido`  out  DIGITS  digit d holds a decoded hex value.
- `erro`  out  DIGITS  last commit on digit d was an unknown pattern.
- `atualizado`  out  1  one-cycle pulse on every commit.

## Operation
- Inputs go through one register stage (`anodos_r`, `segmentos_r`), then are compared with the previous registered sample (`anodos_p`, `segmentos_p`).
- Active-high lit pattern (gfedcba) = `~segmentos_r`. Known patterns: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71. Blank = 00. Anything else is unknown.
- FSM states:
  - IDLE: no valid slot.
  - TRACK: counting stability.
  - HELD: slot already committed.
- Transitions:
  - Any difference between the current and previous registered sample sets the count to 0. The next state is TRACK if `anodos_r` is exactly one-hot-low, otherwise IDLE.
  - TRACK with no change: count increments. When count reaches STABLE-1, commit and go to HELD.
  - HELD with no change: stay in HELD. There is no re-commit.
  - IDLE with no change: stay in IDLE.
- Commit, for digit d = index of the low anode bit:
  - Known pattern: `numeros[d]` ← value, `valido[d]` ← 1, `erro[d]` ← 0.
  - Blank: `numeros[d]` unchanged, `valido[d]` ← 0, `erro[d]` ← 0.
  - Unknown pattern: `numeros[d]` unchanged, `valido[d]` ← 0, `erro[d]` ← 1.
  - In every case, `atualizado` = 1 for exactly that cycle. Other digits are untouched.
- Anodes all high or multi-hot: no commit, regardless of duration.
- Count width is $clog2(STABLE). The count saturates and never wraps.

## Timing
- Reset values: `numeros`=0, `valido`=0, `erro`=0, `atualizado`=0, FSM=IDLE, count=0. Input and compare registers also clear, to all-ones (bus idle).
- Latency: a slot applied before edge e0 and held unchanged commits at edge e0+STABLE. Outputs are visible after that edge.
- A change lasting fewer than STABLE cycles produces no commit. The slot it interrupts restarts its count from zero.
- The same digit re-presented after another slot re-commits. The pulse fires again even if the value is identical.
- Reset asserted mid-count: the count is discarded, no pulse is generated, and all outputs return to reset values on the next edge.
- Inputs are treated as synchronous to `clk`. Off-board synchronisation is outside this block.

## Structure
- Shared package `pkg7s` holds:
  - the active-high gfedcba constants `SEG_0`…`SEG_F` and `SEG_BLANK`, also used by the encoder;
  - the FSM state typedef (IDLE, TRACK, HELD).
- One combinational sub-module, `dec7s`: 7-bit active-low pattern in; 4-bit value, `conhecido` and `apagado` flags out. All other logic is in `le7s_scan`.

## Test plan
- Reset: assert `reset` 2 cycles with random inputs → all outputs 0, no `atualizado`.
- Basic decode (DIGITS=4, STABLE=4): `anodos`=4'b1011, `segmentos`=~7'h6D, held 6 cycles → commit at edge e0+4; `numeros[11:8]`=5, `valido`=4'b0100, one pulse.
- Glitch rejection: after the basic decode, present ~7'h7F for 3 cycles, then restore ~7'h6D → no commit from the glitch. `numeros[11:8]` stays 5 and a single re-commit of 5 occurs.
- Error and blank: digit 0 with pattern ~7'h01 held → `erro[0]`=1, `valido[0]`=0. Then ~7'h00 held → `erro[0]`=0, `valido[0]`=0.
- Invalid anodes: `anodos`=4'b0011 or 4'b1111 held 20 cycles with ~7'h06 → no pulse, outputs unchanged.
- Round trip: drive the encoder plus a 4-digit scanner (STABLE cycles per slot) with all 16 values on every digit → `numeros` equals the driven value and `valido` is all ones. Also assert `reset` at count 2 → no commit.
